reg_writeback_arbiter: RTL

REG_WRITEBACK_ARBITER -- requirements
Module: reg_writeback_arbiter

---
 rtl/reg_pkg.sv | 19 +
 rtl/reg_writeback_arbiter_if.sv | 45 ++++
 rtl/reg_addr_decoder.sv | 18 +
 rtl/reg_writeback_arbiter.sv | 95 +++++++++
 4 files changed

// File: rtl/reg_pkg.sv
// Shared constants for the register bank and its write-back arbiter.
package reg_pkg;

    localparam int NREGS  = 8;
    localparam int WIDTH  = 16;
    localparam int ADDR_W = 3;

    // Write-back port selector; also the encoding of the priority bit.
    typedef enum logic {
        PORT_A = 1'b0,
        PORT_M = 1'b1
    } port_e;

    // The port that gets priority after a port has been granted.
    function automatic port_e other_port(input port_e p);
        return (p == PORT_A) ? PORT_M : PORT_A;
    endfunction

endpackage

// File: rtl/reg_writeback_arbiter_if.sv
// Write-back bus: ALU and load request ports, decode reservation port and
// register-bank/scoreboard outputs.
interface reg_writeback_arbiter_if #(
    parameter int NREGS  = reg_pkg::NREGS,
    parameter int WIDTH  = reg_pkg::WIDTH,
    parameter int ADDR_W = reg_pkg::ADDR_W
);

    logic              a_valid;
    logic [ADDR_W-1:0] a_addr;
    logic [WIDTH-1:0]  a_data;
    logic              a_ready;

    logic              m_valid;
    logic [ADDR_W-1:0] m_addr;
    logic [WIDTH-1:0]  m_data;
    logic              m_ready;

    logic              rsv_valid;
    logic [ADDR_W-1:0] rsv_addr;

    logic [NREGS-1:0]  en;
    logic [WIDTH-1:0]  wr_data;
    logic [NREGS-1:0]  pending;
    logic              err_dbl_rsv;

    // Requesters / decode stage side.
    modport master (
        output a_valid, a_addr, a_data,
        output m_valid, m_addr, m_data,
        output rsv_valid, rsv_addr,
        input  a_ready, m_ready,
        input  en, wr_data, pending, err_dbl_rsv
    );

    // Arbiter side.
    modport slave (
        input  a_valid, a_addr, a_data,
        input  m_valid, m_addr, m_data,
        input  rsv_valid, rsv_addr,
        output a_ready, m_ready,
        output en, wr_data, pending, err_dbl_rsv
    );

endinterface

// File: rtl/reg_addr_decoder.sv
// Binary register address to one-hot enable vector.
module reg_addr_decoder #(
    parameter int ADDR_W = reg_pkg::ADDR_W,
    parameter int NREGS  = reg_pkg::NREGS
) (
    input  logic [ADDR_W-1:0] addr,
    output logic [NREGS-1:0]  onehot
);

    // Compare against every index so addresses beyond NREGS decode to zero.
    always_comb begin
        onehot = '0;
        for (int i = 0; i < NREGS; i++) begin
            onehot[i] = (addr == ADDR_W'(i));
        end
    end

endmodule

// File: rtl/reg_writeback_arbiter.sv
// Two-port (ALU / load) register write-back arbiter with alternating
// priority, registered one-hot write enable and a pending-write scoreboard.
module reg_writeback_arbiter #(
    parameter int NREGS  = reg_pkg::NREGS,
    parameter int WIDTH  = reg_pkg::WIDTH,
    parameter int ADDR_W = reg_pkg::ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    reg_writeback_arbiter_if.slave bus
);

    import reg_pkg::*;

    port_e             prio_q;
    logic              a_take;
    logic              m_take;
    logic              xfer_p0;
    logic [ADDR_W-1:0] xfer_addr_p0;
    logic [WIDTH-1:0]  xfer_data_p0;
    logic [NREGS-1:0]  xfer_onehot_p0;
    logic [NREGS-1:0]  rsv_onehot_p0;
    logic [NREGS-1:0]  pending_d;

    logic [NREGS-1:0]  en_p1;
    logic [WIDTH-1:0]  wr_data_p1;
    logic [NREGS-1:0]  pending_p1;
    logic              err_dbl_rsv_p1;

    // Grant: a lone valid wins, contention goes to the priority port, nothing during reset.
    always_comb begin
        a_take = 1'b0;
        m_take = 1'b0;
        if (!rst) begin
            if (bus.a_valid && (!bus.m_valid || prio_q == PORT_A)) begin
                a_take = 1'b1;
            end else if (bus.m_valid) begin
                m_take = 1'b1;
            end
        end
    end

    assign xfer_p0      = a_take || m_take;
    assign xfer_addr_p0 = m_take ? bus.m_addr : bus.a_addr;
    assign xfer_data_p0 = m_take ? bus.m_data : bus.a_data;

    reg_addr_decoder #(.ADDR_W(ADDR_W), .NREGS(NREGS)) u_xfer_dec (
        .addr   (xfer_addr_p0),
        .onehot (xfer_onehot_p0)
    );

    reg_addr_decoder #(.ADDR_W(ADDR_W), .NREGS(NREGS)) u_rsv_dec (
        .addr   (bus.rsv_addr),
        .onehot (rsv_onehot_p0)
    );

    // Scoreboard update: clear the written register, then set the reserved one so set wins.
    always_comb begin
        pending_d = pending_p1;
        if (xfer_p0) begin
            pending_d = pending_d & ~xfer_onehot_p0;
        end
        if (bus.rsv_valid) begin
            pending_d = pending_d | rsv_onehot_p0;
        end
    end

    // ---- stage p0 -> p1: register write port, scoreboard and priority ----
    always_ff @(posedge clk) begin
        if (rst) begin
            en_p1          <= '0;
            wr_data_p1     <= '0;
            pending_p1     <= '0;
            err_dbl_rsv_p1 <= 1'b0;
            prio_q         <= PORT_A;
        end else begin
            en_p1          <= xfer_p0 ? xfer_onehot_p0 : '0;
            if (xfer_p0) begin
                wr_data_p1 <= xfer_data_p0;
                prio_q     <= other_port(m_take ? PORT_M : PORT_A);
            end
            pending_p1     <= pending_d;
            err_dbl_rsv_p1 <= bus.rsv_valid && |(pending_p1 & rsv_onehot_p0);
        end
    end

    assign bus.a_ready     = a_take;
    assign bus.m_ready     = m_take;
    // A write whose enable lands in a reset cycle is dropped.
    assign bus.en          = en_p1 & {NREGS{~rst}};
    assign bus.wr_data     = wr_data_p1;
    assign bus.pending     = pending_p1;
    assign bus.err_dbl_rsv = err_dbl_rsv_p1;

endmodule
